// File: rtl/fwd_hazard_scoreboard.sv
// EX operand forwarding, load-use and pending-write hazard detection, and EX data-wait
// for a pipeline with NUM_STAGES bypass stages behind EX.
module fwd_hazard_scoreboard #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1),
  parameter int unsigned PEND_W     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]    id_src_addr,
  input  logic [NUM_SRC-1:0]           id_src_valid,
  input  logic [ADDR_W-1:0]            id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_is_load,
  input  logic                         ex_advance,
  input  logic                         flush,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_rd,
  input  logic [NUM_STAGES-1:0]        stage_reg_write,
  input  logic [NUM_STAGES-1:0]        stage_data_ready,
  input  logic                         retire_valid,
  input  logic [ADDR_W-1:0]            retire_rd,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic                         id_stall,
  output logic                         ex_data_wait,
  output logic                         sb_error
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic                               ex_valid_q, ex_valid_d;
  logic [NUM_SRC*ADDR_W-1:0]          ex_src_addr_q, ex_src_addr_d;
  logic [NUM_SRC-1:0]                 ex_src_valid_q, ex_src_valid_d;
  logic [ADDR_W-1:0]                  ex_rd_q, ex_rd_d;
  logic                               ex_reg_write_q, ex_reg_write_d;
  logic                               ex_is_load_q, ex_is_load_d;
  logic [NUM_REGS-1:0][PEND_W-1:0]    pend_q, pend_d;
  logic                               sb_error_q, sb_error_d;

  logic              load_use, sb_hazard, sb_full, stall;
  logic              visible;
  logic [ADDR_W-1:0] src;
  logic              issue, retire;

  logic [NUM_SRC*SEL_W-1:0] sel;
  logic                     data_wait, found;
  logic [ADDR_W-1:0]        ex_src;

  // ID hazards: a producer still in EX or a bypass stage can be forwarded, anything older must wait
  always_comb begin
    load_use  = 1'b0;
    sb_hazard = 1'b0;
    visible   = 1'b0;
    src       = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src     = id_src_addr[s*ADDR_W +: ADDR_W];
      visible = ex_valid_q && ex_reg_write_q && (ex_rd_q == src);
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (stage_reg_write[k] && (stage_rd[k*ADDR_W +: ADDR_W] == src)) visible = 1'b1;
      end
      if (id_valid && id_src_valid[s] && (src != '0)) begin
        if (ex_valid_q && ex_reg_write_q && ex_is_load_q && (ex_rd_q == src)) load_use = 1'b1;
        if ((pend_q[src] != '0) && !visible) sb_hazard = 1'b1;
      end
    end
    sb_full = id_valid && id_reg_write && (id_rd != '0) && (pend_q[id_rd] == PEND_MAX);
    stall   = load_use || sb_hazard || sb_full;
  end

  // EX operand selects: nearest matching stage wins
  always_comb begin
    sel       = '0;
    data_wait = 1'b0;
    found     = 1'b0;
    ex_src    = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      ex_src = ex_src_addr_q[s*ADDR_W +: ADDR_W];
      found  = 1'b0;
      if (ex_valid_q && ex_src_valid_q[s] && (ex_src != '0)) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (!found && stage_reg_write[k] && (stage_rd[k*ADDR_W +: ADDR_W] == ex_src)) begin
            found                  = 1'b1;
            sel[s*SEL_W +: SEL_W]  = SEL_W'(k + 1);
            if (!stage_data_ready[k]) data_wait = 1'b1;
          end
        end
      end
    end
  end

  // ID/EX register and pending-write counters
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_src_addr_d  = ex_src_addr_q;
    ex_src_valid_d = ex_src_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_is_load_d   = ex_is_load_q;
    pend_d         = pend_q;
    sb_error_d     = sb_error_q;

    issue  = ex_advance && id_valid && !flush && !stall && id_reg_write && (id_rd != '0);
    retire = retire_valid && (retire_rd != '0);

    if (ex_advance) begin
      if (flush || stall || !id_valid) begin
        ex_valid_d     = 1'b0;
        ex_src_valid_d = '0;
        ex_reg_write_d = 1'b0;
        ex_is_load_d   = 1'b0;
      end else begin
        ex_valid_d     = 1'b1;
        ex_src_addr_d  = id_src_addr;
        ex_src_valid_d = id_src_valid;
        ex_rd_d        = id_rd;
        ex_reg_write_d = id_reg_write;
        ex_is_load_d   = id_is_load;
      end
    end

    // Simultaneous issue and retire of the same register cancel out
    if (!(issue && retire && (id_rd == retire_rd))) begin
      if (issue) pend_d[id_rd] = pend_q[id_rd] + PEND_W'(1);
      if (retire) begin
        if (pend_q[retire_rd] == '0) sb_error_d = 1'b1;
        else pend_d[retire_rd] = pend_q[retire_rd] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_src_addr_q  <= '0;
      ex_src_valid_q <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
      pend_q         <= '0;
      sb_error_q     <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_src_addr_q  <= ex_src_addr_d;
      ex_src_valid_q <= ex_src_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_is_load_q   <= ex_is_load_d;
      pend_q         <= pend_d;
      sb_error_q     <= sb_error_d;
    end
  end

  assign fwd_sel      = sel;
  assign id_stall     = stall;
  assign ex_data_wait = data_wait;
  assign sb_error     = sb_error_q;

endmodule
